// File: rtl/step_ctrl.sv
// Single-step processor clock-enable controller: synchronizes the push button and
// mode switch, debounces the push, and issues one cpu_en pulse per accepted press.
module step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             ena_switch,
  output logic             cpu_en,
  output logic             push_level,
  output logic             step_mode,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Transition fires on the edge where the count would reach DEBOUNCE_CYCLES-1,
  // giving a total push-rise to push_level latency of 2+DEBOUNCE_CYCLES.
  localparam int unsigned DB_LAST = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  state_t          state;
  logic [DB_W-1:0] db_cnt;
  logic            push_s1;
  logic            push_s2;
  logic            ena_s1;
  logic            db_done_c;
  logic            press_c;

  assign db_done_c = (db_cnt >= DB_W'(DB_LAST));
  assign press_c   = (state == ST_WAIT_HIGH) && push_s2 && db_done_c;

  // Two-flop synchronizers; step_mode is the second ena_switch stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_s1   <= 1'b0;
      push_s2   <= 1'b0;
      ena_s1    <= 1'b0;
      step_mode <= 1'b0;
    end else begin
      push_s1   <= push;
      push_s2   <= push_s1;
      ena_s1    <= ena_switch;
      step_mode <= ena_s1;
    end
  end

  // Debounce FSM with registered push_level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_LOW;
      db_cnt     <= '0;
      push_level <= 1'b0;
    end else begin
      case (state)
        ST_LOW: begin
          if (push_s2) begin
            state  <= ST_WAIT_HIGH;
            db_cnt <= '0;
          end
        end
        ST_WAIT_HIGH: begin
          if (!push_s2) begin
            state  <= ST_LOW;
            db_cnt <= '0;
          end else if (db_done_c) begin
            state      <= ST_HIGH;
            db_cnt     <= '0;
            push_level <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        ST_HIGH: begin
          if (!push_s2) begin
            state  <= ST_WAIT_LOW;
            db_cnt <= '0;
          end
        end
        ST_WAIT_LOW: begin
          if (push_s2) begin
            state  <= ST_HIGH;
            db_cnt <= '0;
          end else if (db_done_c) begin
            state      <= ST_LOW;
            db_cnt     <= '0;
            push_level <= 1'b0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: begin
          state      <= ST_LOW;
          db_cnt     <= '0;
          push_level <= 1'b0;
        end
      endcase
    end
  end

  // cpu_en is judged against the value step_mode takes on this same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else if (ena_s1) begin
      cpu_en <= press_c;
      if (press_c) begin
        step_count <= step_count + CNT_W'(1);
      end
    end else begin
      cpu_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with DEBOUNCE_CYCLES=4, CNT_W=3: vector table for a
// clean single-step press plus hand-written sequences for bounce, mode and reset cases.
module tb_step_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic          ena_switch;
  logic          cpu_en;
  logic          push_level;
  logic          step_mode;
  logic [CW-1:0] step_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          push;
    logic          ena;
    logic          exp_level;
    logic          exp_cpu;
    logic          exp_mode;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t tbl[20];

  step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .ena_switch (ena_switch),
    .cpu_en     (cpu_en),
    .push_level (push_level),
    .step_mode  (step_mode),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic lvl, input logic cpu,
                            input logic mode, input logic [CW-1:0] cnt);
    chk($sformatf("%s.push_level", tag), 32'(push_level), 32'(lvl));
    chk($sformatf("%s.cpu_en", tag), 32'(cpu_en), 32'(cpu));
    chk($sformatf("%s.step_mode", tag), 32'(step_mode), 32'(mode));
    chk($sformatf("%s.step_count", tag), 32'(step_count), 32'(cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    logic [CW-1:0] cnt0;

    // Clean press and release in single-step mode, starting from LOW with count 0.
    for (int i = 0; i < 5; i++)   tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1};
    for (int i = 6; i < 10; i++)  tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1};
    for (int i = 10; i < 15; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1};
    for (int i = 15; i < 20; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1};

    reset = 1'b0;
    push = 1'b0;
    ena_switch = 1'b0;
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 3'd0);

    // Release reset between edges: cpu_en stays 0 until the first edge.
    reset = 1'b1;
    #1;
    chk("release.cpu_en", 32'(cpu_en), 32'd0);
    for (int c = 0; c < 8; c++) begin
      tick();
      check_outs($sformatf("freerun%0d", c), 1'b0, 1'b1, 1'b0, 3'd0);
    end

    // Switch to single-step: cpu_en drops exactly when step_mode rises.
    ena_switch = 1'b1;
    tick();
    check_outs("mode01.a", 1'b0, 1'b1, 1'b0, 3'd0);
    tick();
    check_outs("mode01.b", 1'b0, 1'b0, 1'b1, 3'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_outs("mode01.idle", 1'b0, 1'b0, 1'b1, 3'd0);
    end

    for (int i = 0; i < 20; i++) begin
      push = tbl[i].push;
      ena_switch = tbl[i].ena;
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].exp_level, tbl[i].exp_cpu,
                 tbl[i].exp_mode, tbl[i].exp_cnt);
    end

    // Bounce: push toggles every 2 cycles, never stable long enough.
    for (int c = 0; c < 30; c++) begin
      push = ((c / 2) % 2 == 0);
      tick();
      check_outs($sformatf("bounce%0d", c), 1'b0, 1'b0, 1'b1, 3'd1);
    end
    push = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check_outs("bounce.settle", 1'b0, 1'b0, 1'b1, 3'd1);
    end

    // Three clean presses, 10 high / 10 low.
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 20; c++) begin
        push = (c < 10);
        tick();
        check_outs($sformatf("press%0d.%0d", p, c), (c >= 5 && c < 15), (c == 5), 1'b1,
                   CW'(1 + p + ((c >= 5) ? 1 : 0)));
      end
    end

    // Press accepted on the very edge where step_mode becomes 1.
    ena_switch = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check_outs("sync.free", 1'b0, 1'b1, 1'b0, 3'd4);
    push = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    ena_switch = 1'b1;
    tick();
    check_outs("sync.c4", 1'b0, 1'b1, 1'b0, 3'd4);
    tick();
    check_outs("sync.c5", 1'b1, 1'b1, 1'b1, 3'd5);
    tick();
    check_outs("sync.c6", 1'b1, 1'b0, 1'b1, 3'd5);
    push = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check_outs("sync.rel", 1'b0, 1'b0, 1'b1, 3'd5);

    // Mode 0->1 while push is held: no pulse until a new press.
    ena_switch = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    push = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("held.free.cpu_en", 32'(cpu_en), 32'd1);
    end
    check_outs("held.free", 1'b1, 1'b1, 1'b0, 3'd5);
    ena_switch = 1'b1;
    tick();
    check_outs("held.m1", 1'b1, 1'b1, 1'b0, 3'd5);
    tick();
    check_outs("held.m2", 1'b1, 1'b0, 1'b1, 3'd5);
    pulses = 0;
    for (int c = 0; c < 18; c++) begin
      push = (c < 8);
      tick();
      if (cpu_en === 1'b1) pulses++;
    end
    chk("held.no_pulse", 32'(pulses), 32'd0);
    check_outs("held.low", 1'b0, 1'b0, 1'b1, 3'd5);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      push = (c < 10);
      tick();
      if (cpu_en === 1'b1) pulses++;
    end
    chk("repress.pulses", 32'(pulses), 32'd1);
    chk("repress.count", 32'(step_count), 32'd6);

    // Two more presses wrap the 3-bit counter 7 -> 0.
    for (int p = 0; p < 2; p++) begin
      cnt0 = step_count;
      for (int c = 0; c < 20; c++) begin
        push = (c < 10);
        tick();
      end
      chk($sformatf("wrap%0d.count", p), 32'(step_count), 32'(CW'(cnt0 + CW'(1))));
    end
    chk("wrap.zero", 32'(step_count), 32'd0);

    // Reset 3 cycles into a debounce; push stays held across it.
    push = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    reset = 1'b0;
    tick();
    check_outs("midrst", 1'b0, 1'b0, 1'b0, 3'd0);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_outs($sformatf("postrst%0d", c), (c >= 5), (c == 0 || c == 5), (c >= 1),
                 CW'((c >= 5) ? 1 : 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
